seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//   Parametrised multi-cycle ALU for WIDTH-bit operands: AND/OR/XOR, ADD/SUB, multiply and divide.
//   - Operation selected per request; start/busy/done handshake.
//   - Successor of the fixed 8-bit FSM ALU: generic width, unsigned/signed multiply mode,
//     remainder output, status flags.
//   - Sits between operand registers and the result bus; one request in flight at a time.
// PARAMETERS
//   WIDTH       8   operand width in bits, >= 2; result is 2*WIDTH bits
//   SIGNED_MUL  1   1: two's-complement radix-2 Booth multiply; 0: unsigned shift-add multiply
// PORTS
//   clk      in   1        rising-edge clock, single clock domain
//   reset    in   1        asynchronous, active-high reset
//   start    in   1        request strobe, sampled only in IDLE
//   op       in   3        000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 DIV, 111 reserved
//   x        in   WIDTH    operand X (multiplicand / dividend)
//   y        in   WIDTH    operand Y (multiplier / divisor)
//   busy     out  1        high in every state except IDLE
//   done     out  1        one-cycle pulse: result and flags valid
//   result   out  2*WIDTH  see arithmetic rules
//   ovf      out  1        signed overflow (ADD/SUB only)
//   carry    out  1        ADD carry-out; SUB not-borrow (1 when x >= y unsigned)
//   zero     out  1        result == 0 (all 2*WIDTH bits)
//   dbz      out  1        DIV with y == 0
//   err      out  1        reserved opcode 111
// BEHAVIOUR
//   Reset:
//     - state IDLE; busy, done, result, all flags = 0.
//     - Reset mid-operation aborts immediately; no done is produced.
//   FSM states:
//     - IDLE -> RUN on start=1: x, y, op latched at that edge (E); iteration counter cleared.
//     - RUN -> FIN after 1 cycle (logic/ADD/SUB/111) or after WIDTH cycles (MUL/DIV).
//     - FIN -> IDLE unconditionally. done = 1 only in FIN.
//   Latency:
//     - Logic/ADD/SUB/111: done high in the cycle after edge E+1.
//     - MUL/DIV: done high in the cycle after edge E+WIDTH.
//   Handshake:
//     - start ignored while busy (RUN or FIN); inputs may change freely after E.
//     - Next request is accepted no earlier than the first IDLE cycle after FIN.
//   Result retention:
//     - result and flags update only at the edge entering FIN.
//     - Held stable until the next completion or reset.
//   Arithmetic (all results zero-extended to 2*WIDTH unless stated):
//     - AND/OR/XOR: {WIDTH'0, x op y}; ovf = carry = 0.
//     - ADD/SUB: low half = x +/- y mod 2^WIDTH; high half 0; ovf/carry as defined above.
//     - MUL, SIGNED_MUL=1: full 2*WIDTH two's-complement product.
//       One Booth step per cycle (add/sub/none on the {q0,q-1} pair, then arithmetic right shift).
//     - MUL, SIGNED_MUL=0: unsigned product, one shift-add per cycle.
//     - DIV: unsigned restoring division, one quotient bit per cycle; result = {remainder, quotient}.
//     - DIV with y == 0: quotient = all ones, remainder = x, dbz = 1; still takes WIDTH cycles.
//     - 111: result = 0, err = 1.
//     - Flags not meaningful for the op are 0. zero is computed for every op.
//   Counter:
//     - Counter width is $clog2(WIDTH+1).
//     - Terminal count WIDTH-1 triggers RUN->FIN; no wrap beyond it.
// TESTING (WIDTH=8 unless noted)
//   1. MUL, SIGNED_MUL=1, x=8'hFD (-3), y=8'h05 -> done after E+8, result=16'hFFF1, zero=0.
//      Same with SIGNED_MUL=0 -> result=16'h04F1.
//   2. DIV x=200, y=7 -> result=16'h041C (r=4, q=28), dbz=0.
//      DIV x=8'h55, y=0 -> result=16'h55FF, dbz=1.
//   3. ADD 8'h7F+8'h01 -> result=16'h0080, ovf=1, carry=0.
//      SUB 8'h00-8'h01 -> result=16'h00FF, ovf=0, carry=0.
//      ADD 8'hFF+8'h01 -> zero=1, carry=1.
//   4. XOR 8'hA5^8'hA5 -> zero=1, done after E+1.
//      op=111 -> result=0, err=1, single-cycle latency.
//   5. Handshake: start during RUN and FIN of a MUL -> ignored; result is the first request's only.
//      Hold start=1 continuously -> a new request every WIDTH+2 cycles.
//   6. Assert reset at E+4 of a MUL -> outputs 0 immediately, no done.
//      New DIV after release completes correctly.
//      Repeat 1-3 with WIDTH=16 and WIDTH=2.

Source files
------------

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
//   Multi-cycle ALU for WIDTH-bit operands. It supports the logic operations,
//   ADD/SUB, multiply (radix-2 Booth or unsigned shift-add) and unsigned
//   restoring divide. Only one request is in flight at a time. A request is
//   taken from start/op/x/y in IDLE, and the answer is presented with a
//   one-cycle done pulse.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   start   request strobe, only looked at in IDLE
//   op      000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 DIV,
//           111 reserved
//   x, y    operands (x = multiplicand/dividend, y = multiplier/divisor)
//   busy    high in RUN and FIN
//   done    high for the single FIN cycle
//   result  2*WIDTH-bit result, held until the next completion or reset
//   ovf     signed overflow (ADD/SUB)
//   carry   ADD carry-out / SUB not-borrow
//   zero    result is all zeros
//   dbz     divide by zero
//   err     reserved opcode
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_MUL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               ovf,
    output logic               carry,
    output logic               zero,
    output logic               dbz,
    output logic               err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   x_reg, y_reg;
    // acc is one bit wider than an operand. This headroom keeps the Booth
    // add/sub correct when the multiplicand is the most negative value. It
    // also holds the unsigned shift-add carry and the trial remainder.
    logic [WIDTH:0]     acc_reg, acc_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic               qm1_reg, qm1_next;
    logic [CW-1:0]      cnt_reg;

    logic               is_iter, last_step;
    logic [WIDTH:0]     m_ext, sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH:0]     add_full, sub_full;
    logic [2*WIDTH-1:0] res_calc;
    logic               ovf_calc, carry_calc, dbz_calc, err_calc;

    assign is_iter   = (op_reg == OP_MUL) || (op_reg == OP_DIV);
    assign last_step = (cnt_reg == CW'(WIDTH - 1));
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_FIN);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (!is_iter || last_step) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- one multiply / divide step ----------------
    always_comb begin
        m_ext    = SIGNED_MUL ? {x_reg[WIDTH-1], x_reg} : {1'b0, x_reg};
        sum      = acc_reg;
        shifted  = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, y_reg};
        acc_next = acc_reg;
        q_next   = q_reg;
        qm1_next = qm1_reg;
        if (op_reg == OP_DIV) begin
            // Restoring divide. The dividend bits shift out of q into the
            // remainder, and each quotient bit shifts in at the bottom.
            if (!diff[WIDTH+1]) begin
                acc_next = diff[WIDTH:0];
                q_next   = {q_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted;
                q_next   = {q_reg[WIDTH-2:0], 1'b0};
            end
        end else if (SIGNED_MUL) begin
            case ({q_reg[0], qm1_reg})
                2'b01:   sum = acc_reg + m_ext;
                2'b10:   sum = acc_reg - m_ext;
                default: sum = acc_reg;
            endcase
            acc_next = {sum[WIDTH], sum[WIDTH:1]};
            q_next   = {sum[0], q_reg[WIDTH-1:1]};
            qm1_next = q_reg[0];
        end else begin
            sum      = q_reg[0] ? (acc_reg + m_ext) : acc_reg;
            acc_next = {1'b0, sum[WIDTH:1]};
            q_next   = {sum[0], q_reg[WIDTH-1:1]};
        end
    end

    // ---------------- final result and flags ----------------
    always_comb begin
        add_full   = {1'b0, x_reg} + {1'b0, y_reg};
        sub_full   = {1'b0, x_reg} - {1'b0, y_reg};
        res_calc   = '0;
        ovf_calc   = 1'b0;
        carry_calc = 1'b0;
        dbz_calc   = 1'b0;
        err_calc   = 1'b0;
        case (op_reg)
            OP_AND: res_calc = {{WIDTH{1'b0}}, x_reg & y_reg};
            OP_OR:  res_calc = {{WIDTH{1'b0}}, x_reg | y_reg};
            OP_XOR: res_calc = {{WIDTH{1'b0}}, x_reg ^ y_reg};
            OP_ADD: begin
                res_calc   = {{WIDTH{1'b0}}, add_full[WIDTH-1:0]};
                carry_calc = add_full[WIDTH];
                ovf_calc   = (x_reg[WIDTH-1] == y_reg[WIDTH-1]) &&
                             (add_full[WIDTH-1] != x_reg[WIDTH-1]);
            end
            OP_SUB: begin
                res_calc   = {{WIDTH{1'b0}}, sub_full[WIDTH-1:0]};
                carry_calc = ~sub_full[WIDTH];
                ovf_calc   = (x_reg[WIDTH-1] != y_reg[WIDTH-1]) &&
                             (sub_full[WIDTH-1] != x_reg[WIDTH-1]);
            end
            // The last step happens at the edge that enters FIN, so the
            // result is taken from the step outputs, not the registers.
            // Multiply gives {high, low}; divide gives {remainder, quotient}.
            OP_MUL: res_calc = {acc_next[WIDTH-1:0], q_next};
            OP_DIV: begin
                res_calc = {acc_next[WIDTH-1:0], q_next};
                dbz_calc = (y_reg == '0);
            end
            default: err_calc = 1'b1;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg  <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            acc_reg <= '0;
            q_reg   <= '0;
            qm1_reg <= 1'b0;
            cnt_reg <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            dbz     <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && start) begin
                op_reg  <= op;
                x_reg   <= x;
                y_reg   <= y;
                acc_reg <= '0;
                q_reg   <= (op == OP_DIV) ? x : y;
                qm1_reg <= 1'b0;
                cnt_reg <= '0;
            end else if (state_reg == S_RUN) begin
                if (is_iter) begin
                    acc_reg <= acc_next;
                    q_reg   <= q_next;
                    qm1_reg <= qm1_next;
                    if (!last_step) cnt_reg <= cnt_reg + CW'(1);
                end
                if (state_next == S_FIN) begin
                    result <= res_calc;
                    ovf    <= ovf_calc;
                    carry  <= carry_calc;
                    zero   <= (res_calc == '0);
                    dbz    <= dbz_calc;
                    err    <= err_calc;
                end
            end
        end
    end

endmodule
